alarm_clock_ctrl: RTL and testbench

- Control FSM for the alarm clock datapath.
- Collects keypad digits into a 4-digit entry buffer and validates the entry.
- Pulses load_new_a into the alarm register, or load_new_c into the clock counter.
- Sequences the display mode and raises sound_alarm when current time equals stored alarm time.

---
 rtl/alarm_clock_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock control FSM: keypad entry buffer, validation, load pulses, display select and alarm sounding.
// Optional snooze timer is built when SNOOZE_EN is defined.
module alarm_clock_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10
`ifdef SNOOZE_EN
    , parameter int unsigned SNOOZE_MIN = 5
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_strobe,
    input  logic [3:0] key_digit,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic [3:0] current_ms_hr,
    input  logic [3:0] current_ls_hr,
    input  logic [3:0] current_ms_min,
    input  logic [3:0] current_ls_min,
    input  logic [3:0] alarm_ms_hr,
    input  logic [3:0] alarm_ls_hr,
    input  logic [3:0] alarm_ms_min,
    input  logic [3:0] alarm_ls_min,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_alarm,
    output logic       show_new_time,
    output logic       entry_err,
    output logic       sound_alarm
);

    localparam int unsigned DW = 4;
    localparam int unsigned BW = 4 * DW;
    localparam int unsigned CW = 3;
    localparam int unsigned TW = 8;
`ifdef SNOOZE_EN
    localparam int unsigned SW = 10;
    localparam int unsigned SNOOZE_TICKS = SNOOZE_MIN * 60;
`endif

    typedef enum logic [1:0] {IDLE, ENTRY, SHOW_ALARM} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   entry_q, entry_nxt;
    logic [CW-1:0]   count_q, count_nxt;
    logic [TW-1:0]   timeout_q, timeout_nxt;
    logic            alarm_btn_q, time_btn_q, match_q;
    logic            load_a_nxt, load_c_nxt, err_nxt, sound_nxt;
`ifdef SNOOZE_EN
    logic [SW-1:0]   snooze_cnt_q, snooze_cnt_nxt;
    logic            pending_q, pending_nxt;
    logic            resound_q, resound_nxt;
`endif

    logic alarm_press, time_press, key_valid, match, entry_ok, silence;
    logic [DW-1:0] e_ms_hr, e_ls_hr, e_ms_min;

    assign alarm_press = alarm_button & ~alarm_btn_q;
    assign time_press  = time_button & ~time_btn_q;
    assign key_valid   = key_strobe && (key_digit <= DW'(9));
    assign match       = {current_ms_hr, current_ls_hr, current_ms_min, current_ls_min}
                      == {alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min};
    // An alarm press while sounding only silences the buzzer.
    assign silence     = alarm_press & sound_alarm;

    assign e_ms_hr  = entry_q[15:12];
    assign e_ls_hr  = entry_q[11:8];
    assign e_ms_min = entry_q[7:4];
    assign entry_ok = (count_q == CW'(4)) && (e_ms_hr <= DW'(2)) && (e_ls_hr <= DW'(9))
                   && ((e_ms_hr != DW'(2)) || (e_ls_hr <= DW'(3))) && (e_ms_min <= DW'(5));

    assign new_ms_hr  = entry_q[15:12];
    assign new_ls_hr  = entry_q[11:8];
    assign new_ms_min = entry_q[7:4];
    assign new_ls_min = entry_q[3:0];

    // Next-state, entry datapath and pulse decode
    always_comb begin
        state_nxt   = state;
        entry_nxt   = entry_q;
        count_nxt   = count_q;
        timeout_nxt = timeout_q;
        load_a_nxt  = 1'b0;
        load_c_nxt  = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (silence) begin
                    state_nxt = IDLE;
                end else if (alarm_press) begin
                    state_nxt = SHOW_ALARM;
                end else if (time_press) begin
                    state_nxt = IDLE;
                end else if (key_valid) begin
                    entry_nxt   = {entry_q[BW-DW-1:0], key_digit};
                    count_nxt   = CW'(1);
                    timeout_nxt = '0;
                    state_nxt   = ENTRY;
                end
            end
            ENTRY: begin
                if (silence) begin
                    state_nxt = ENTRY;
                end else if (alarm_press || time_press) begin
                    if (entry_ok) begin
                        load_a_nxt = alarm_press;
                        load_c_nxt = ~alarm_press;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (key_valid) begin
                    entry_nxt   = {entry_q[BW-DW-1:0], key_digit};
                    count_nxt   = (count_q == CW'(4)) ? CW'(4) : count_q + CW'(1);
                    timeout_nxt = '0;
                end else if (one_second) begin
                    if (timeout_q == TW'(TIMEOUT_TICKS - 1)) begin
                        entry_nxt   = '0;
                        count_nxt   = '0;
                        timeout_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        timeout_nxt = timeout_q + TW'(1);
                    end
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buzzer set/clear, independent of the entry FSM
    always_comb begin
        sound_nxt = sound_alarm;
`ifdef SNOOZE_EN
        snooze_cnt_nxt = snooze_cnt_q;
        pending_nxt    = pending_q;
        resound_nxt    = resound_q;
`endif
        if (match && !match_q) sound_nxt = 1'b1;
`ifdef SNOOZE_EN
        if (!match && match_q && !resound_q) sound_nxt = 1'b0;
        if (pending_q && one_second) begin
            if (snooze_cnt_q == SW'(1)) begin
                sound_nxt      = 1'b1;
                resound_nxt    = 1'b1;
                pending_nxt    = 1'b0;
                snooze_cnt_nxt = '0;
            end else begin
                snooze_cnt_nxt = snooze_cnt_q - SW'(1);
            end
        end
        if (time_press && !alarm_press && sound_alarm && state == IDLE) begin
            sound_nxt      = 1'b0;
            pending_nxt    = 1'b1;
            snooze_cnt_nxt = SW'(SNOOZE_TICKS);
        end
        if (alarm_press || load_a_nxt) begin
            pending_nxt    = 1'b0;
            snooze_cnt_nxt = '0;
        end
`else
        if (!match && match_q) sound_nxt = 1'b0;
`endif
        if (silence) sound_nxt = 1'b0;
`ifdef SNOOZE_EN
        if (!sound_nxt) resound_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            entry_q       <= '0;
            count_q       <= '0;
            timeout_q     <= '0;
            alarm_btn_q   <= 1'b0;
            time_btn_q    <= 1'b0;
            match_q       <= 1'b0;
            load_new_a    <= 1'b0;
            load_new_c    <= 1'b0;
            entry_err     <= 1'b0;
            show_alarm    <= 1'b0;
            show_new_time <= 1'b0;
            sound_alarm   <= 1'b0;
        end else begin
            state         <= state_nxt;
            entry_q       <= entry_nxt;
            count_q       <= count_nxt;
            timeout_q     <= timeout_nxt;
            alarm_btn_q   <= alarm_button;
            time_btn_q    <= time_button;
            match_q       <= match;
            load_new_a    <= load_a_nxt;
            load_new_c    <= load_c_nxt;
            entry_err     <= err_nxt;
            show_alarm    <= (state_nxt == SHOW_ALARM);
            show_new_time <= (state_nxt == ENTRY);
            sound_alarm   <= sound_nxt;
        end
    end

`ifdef SNOOZE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            snooze_cnt_q <= '0;
            pending_q    <= 1'b0;
            resound_q    <= 1'b0;
        end else begin
            snooze_cnt_q <= snooze_cnt_nxt;
            pending_q    <= pending_nxt;
            resound_q    <= resound_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl: entry, validation, timeout, display, sounding and reset.
module tb_alarm_clock_ctrl;

    logic       clk = 1'b0;
    logic       reset, one_second, key_strobe, alarm_button, time_button;
    logic [3:0] key_digit;
    logic [3:0] current_ms_hr, current_ls_hr, current_ms_min, current_ls_min;
    logic [3:0] alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
    logic       load_new_a, load_new_c, show_alarm, show_new_time, entry_err, sound_alarm;
    logic [15:0] new_t;
    int tests = 0;
    int fails = 0;

    assign new_t = {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};

    always #5 clk = ~clk;

    alarm_clock_ctrl #(
        .TIMEOUT_TICKS(10)
`ifdef SNOOZE_EN
        , .SNOOZE_MIN(1)
`endif
    ) dut (
        .clk(clk), .reset(reset), .one_second(one_second),
        .key_strobe(key_strobe), .key_digit(key_digit),
        .alarm_button(alarm_button), .time_button(time_button),
        .current_ms_hr(current_ms_hr), .current_ls_hr(current_ls_hr),
        .current_ms_min(current_ms_min), .current_ls_min(current_ls_min),
        .alarm_ms_hr(alarm_ms_hr), .alarm_ls_hr(alarm_ls_hr),
        .alarm_ms_min(alarm_ms_min), .alarm_ls_min(alarm_ls_min),
        .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
        .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
        .load_new_a(load_new_a), .load_new_c(load_new_c),
        .show_alarm(show_alarm), .show_new_time(show_new_time),
        .entry_err(entry_err), .sound_alarm(sound_alarm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_strobe = 1'b1;
        key_digit  = d;
        tick();
        key_strobe = 1'b0;
    endtask

    task automatic set_cur(input logic [15:0] t);
        {current_ms_hr, current_ls_hr, current_ms_min, current_ls_min} = t;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; one_second = 1'b0; key_strobe = 1'b0; key_digit = '0;
        alarm_button = 1'b0; time_button = 1'b0;
        set_cur(16'h1200);
        {alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min} = 16'h0630;
        tick(); tick();
        chk("reset_outputs", {10'd0, load_new_a, load_new_c, entry_err, show_alarm,
            show_new_time, sound_alarm, new_t}, 32'd0);
        reset = 1'b0;

        // Load alarm 07:30
        key(4'd0);
        chk("entry_show", {31'd0, show_new_time}, 32'd1);
        key(4'd7); key(4'd3); key(4'd0);
        alarm_button = 1'b1; tick();
        chk("load_a_pulse", {load_new_a, load_new_c, entry_err, show_new_time}, 4'b1000);
        chk("load_a_value", {16'd0, new_t}, 32'h0730);
        alarm_button = 1'b0; tick();
        chk("load_a_width", {load_new_a, load_new_c, entry_err, show_new_time}, 4'b0000);

        // 24:00 rejected, then 12:59 loads clock
        key(4'd2); key(4'd4); key(4'd0); key(4'd0);
        time_button = 1'b1; tick();
        chk("err_2400", {load_new_a, load_new_c, entry_err}, 3'b001);
        time_button = 1'b0; tick();
        chk("err_width", {load_new_a, load_new_c, entry_err, show_new_time}, 4'b0000);
        key(4'd1); key(4'd2); key(4'd5); key(4'd9);
        time_button = 1'b1; tick();
        chk("load_c_pulse", {load_new_a, load_new_c, entry_err}, 3'b010);
        chk("load_c_value", {16'd0, new_t}, 32'h1259);
        time_button = 1'b0; tick();

        // Boundaries: 23:59 valid, 3 digits invalid, minutes 60 invalid
        key(4'd2); key(4'd3); key(4'd5); key(4'd9);
        alarm_button = 1'b1; tick();
        chk("valid_2359", {load_new_a, load_new_c, entry_err}, 3'b100);
        alarm_button = 1'b0; tick();
        key(4'd1); key(4'd2); key(4'd3);
        alarm_button = 1'b1; tick();
        chk("short_entry", {load_new_a, load_new_c, entry_err}, 3'b001);
        alarm_button = 1'b0; tick();
        key(4'd0); key(4'd9); key(4'd6); key(4'd0);
        time_button = 1'b1; tick();
        chk("bad_minutes", {load_new_a, load_new_c, entry_err}, 3'b001);
        time_button = 1'b0; tick();

        // Overflow shift and timeout
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("shift_5", {16'd0, new_t}, 32'h2345);
        key(4'd11);
        chk("bad_digit", {16'd0, new_t}, 32'h2345);
        key(4'd9);
        chk("shift_6", {16'd0, new_t}, 32'h3459);
        for (int i = 0; i < 9; i++) begin
            one_second = 1'b1; tick(); one_second = 1'b0; tick();
        end
        chk("pre_timeout", {31'd0, show_new_time}, 32'd1);
        one_second = 1'b1; tick(); one_second = 1'b0;
        chk("timeout", {load_new_a, load_new_c, entry_err, show_new_time, new_t}, 20'd0);

        // Show alarm while held; keys ignored
        alarm_button = 1'b1; tick();
        chk("show_alarm_on", {show_alarm, show_new_time}, 2'b10);
        key(4'd5);
        chk("show_alarm_key", {show_alarm, show_new_time}, 2'b10);
        alarm_button = 1'b0; tick();
        chk("show_alarm_off", {show_alarm, show_new_time}, 2'b00);

        // Sounding: silence by press, then by minute end
        set_cur(16'h0629); tick();
        chk("no_sound", {31'd0, sound_alarm}, 32'd0);
        set_cur(16'h0630); tick();
        chk("sound_on", {31'd0, sound_alarm}, 32'd1);
        alarm_button = 1'b1; tick();
        chk("sound_press", {sound_alarm, show_alarm}, 2'b00);
        alarm_button = 1'b0; tick();
        chk("sound_press2", {sound_alarm, show_alarm}, 2'b00);
        set_cur(16'h0629); tick();
        set_cur(16'h0630); tick();
        chk("sound_on2", {31'd0, sound_alarm}, 32'd1);
        tick();
        chk("sound_hold", {31'd0, sound_alarm}, 32'd1);
        set_cur(16'h0631); tick();
        chk("sound_minute_end", {31'd0, sound_alarm}, 32'd0);

`ifdef SNOOZE_EN
        set_cur(16'h0629); tick();
        set_cur(16'h0630); tick();
        chk("snz_sound", {31'd0, sound_alarm}, 32'd1);
        time_button = 1'b1; tick();
        chk("snz_press", {31'd0, sound_alarm}, 32'd0);
        time_button = 1'b0; tick();
        for (int i = 0; i < 59; i++) begin
            one_second = 1'b1; tick(); one_second = 1'b0; tick();
        end
        chk("snz_wait", {31'd0, sound_alarm}, 32'd0);
        one_second = 1'b1; tick(); one_second = 1'b0;
        chk("snz_resound", {31'd0, sound_alarm}, 32'd1);
        set_cur(16'h1200); tick();
        chk("snz_no_min_end", {31'd0, sound_alarm}, 32'd1);
        alarm_button = 1'b1; tick();
        chk("snz_press_off", {31'd0, sound_alarm}, 32'd0);
        alarm_button = 1'b0; tick();
`else
        set_cur(16'h0629); tick();
        set_cur(16'h0630); tick();
        chk("nosnz_sound", {31'd0, sound_alarm}, 32'd1);
        time_button = 1'b1; tick();
        chk("nosnz_time", {31'd0, sound_alarm}, 32'd1);
        time_button = 1'b0; tick();
        set_cur(16'h1200); tick();
        chk("nosnz_end", {31'd0, sound_alarm}, 32'd0);
`endif

        // Simultaneous presses: alarm wins
        key(4'd1); key(4'd1); key(4'd1); key(4'd1);
        alarm_button = 1'b1; time_button = 1'b1; tick();
        chk("both_press", {load_new_a, load_new_c, entry_err}, 3'b100);
        alarm_button = 1'b0; time_button = 1'b0; tick();
        chk("both_width", {load_new_a, load_new_c, entry_err}, 3'b000);

        // Reset mid-entry
        key(4'd1); key(4'd2);
        chk("mid_entry", {15'd0, show_new_time, new_t}, 32'h1_1112);
        reset = 1'b1; tick();
        chk("reset_mid", {10'd0, load_new_a, load_new_c, entry_err, show_alarm,
            show_new_time, sound_alarm, new_t}, 32'd0);
        reset = 1'b0; tick();
        key(4'd3);
        chk("after_reset", {15'd0, show_new_time, new_t}, 32'h1_0003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
